// File: rtl/alu_writeback.sv
// Writeback stage behind the ALU: architectural accumulator and Z/C flags,
// a one-deep buffered register-file write with forwarding, and an interrupt shadow.
module alu_writeback #(
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            result,
    input  logic                  accum_write,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] reg_addr,
    input  logic                  z_write,
    input  logic                  zout,
    input  logic                  c_write,
    input  logic                  cout,
    output logic [7:0]            accum,
    output logic                  zflag,
    output logic                  cflag,
    output logic                  rf_wr_en,
    output logic [ADDR_WIDTH-1:0] rf_wr_addr,
    output logic [7:0]            rf_wr_data,
    input  logic                  rf_wr_ack,
    output logic                  fwd_valid,
    output logic [ADDR_WIDTH-1:0] fwd_addr,
    output logic [7:0]            fwd_data,
    input  logic                  irq_save,
    input  logic                  irq_restore,
    output logic [CNT_WIDTH-1:0]  retire_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                  pend_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [7:0]            data_r;
    logic [7:0]            accum_r;
    logic                  zflag_r;
    logic                  cflag_r;
    logic [7:0]            sh_accum_r;
    logic                  sh_z_r;
    logic                  sh_c_r;
    logic [CNT_WIDTH-1:0]  cnt_r;

    logic                  ready_s;
    logic                  accept_s;
    logic                  pend_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [7:0]            data_s;
    logic [7:0]            accum_s;
    logic                  zflag_s;
    logic                  cflag_s;
    logic [7:0]            sh_accum_s;
    logic                  sh_z_s;
    logic                  sh_c_s;
    logic [CNT_WIDTH-1:0]  cnt_s;

    // A pending write retiring this cycle frees the slot for a same-cycle accept.
    assign ready_s  = !pend_r || rf_wr_ack;
    assign accept_s = in_valid && ready_s;

    // Pending register-file write slot and retired-operation counter.
    always_comb begin
        pend_s = pend_r;
        addr_s = addr_r;
        data_s = data_r;
        cnt_s  = cnt_r;
        if (accept_s && reg_write) begin
            pend_s = 1'b1;
            addr_s = reg_addr;
            data_s = result;
        end else if (rf_wr_ack) begin
            pend_s = 1'b0;
        end else begin
            pend_s = pend_r;
        end
        if (accept_s) begin
            cnt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Architectural accumulator/flags and shadow; restore overrides any accept update.
    always_comb begin
        accum_s    = accum_r;
        zflag_s    = zflag_r;
        cflag_s    = cflag_r;
        sh_accum_s = sh_accum_r;
        sh_z_s     = sh_z_r;
        sh_c_s     = sh_c_r;
        if (irq_restore) begin
            accum_s = sh_accum_r;
            zflag_s = sh_z_r;
            cflag_s = sh_c_r;
        end else if (accept_s) begin
            if (accum_write) begin
                accum_s = result;
            end else begin
                accum_s = accum_r;
            end
            if (z_write) begin
                zflag_s = zout;
            end else begin
                zflag_s = zflag_r;
            end
            if (c_write) begin
                cflag_s = cout;
            end else begin
                cflag_s = cflag_r;
            end
        end else begin
            accum_s = accum_r;
        end
        // Save captures pre-edge state, so save+restore together swaps the two copies.
        if (irq_save) begin
            sh_accum_s = accum_r;
            sh_z_s     = zflag_r;
            sh_c_s     = cflag_r;
        end else begin
            sh_accum_s = sh_accum_r;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_r     <= 1'b0;
            addr_r     <= {ADDR_WIDTH{1'b0}};
            data_r     <= 8'h00;
            accum_r    <= 8'h00;
            zflag_r    <= 1'b0;
            cflag_r    <= 1'b0;
            sh_accum_r <= 8'h00;
            sh_z_r     <= 1'b0;
            sh_c_r     <= 1'b0;
            cnt_r      <= {CNT_WIDTH{1'b0}};
        end else begin
            pend_r     <= pend_s;
            addr_r     <= addr_s;
            data_r     <= data_s;
            accum_r    <= accum_s;
            zflag_r    <= zflag_s;
            cflag_r    <= cflag_s;
            sh_accum_r <= sh_accum_s;
            sh_z_r     <= sh_z_s;
            sh_c_r     <= sh_c_s;
            cnt_r      <= cnt_s;
        end
    end

    assign in_ready     = ready_s;
    assign accum        = accum_r;
    assign zflag        = zflag_r;
    assign cflag        = cflag_r;
    assign rf_wr_en     = pend_r;
    assign rf_wr_addr   = addr_r;
    assign rf_wr_data   = data_r;
    assign fwd_valid    = pend_r;
    assign fwd_addr     = addr_r;
    assign fwd_data     = data_r;
    assign retire_count = cnt_r;

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus random traffic
// checked against an architectural reference model and an in-order write scoreboard.
module tb_alu_writeback;

    localparam int AW = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid, in_ready;
    logic [7:0]    result;
    logic          accum_write, reg_write;
    logic [AW-1:0] reg_addr;
    logic          z_write, zout, c_write, cout;
    logic [7:0]    accum;
    logic          zflag, cflag;
    logic          rf_wr_en;
    logic [AW-1:0] rf_wr_addr;
    logic [7:0]    rf_wr_data;
    logic          rf_wr_ack;
    logic          fwd_valid;
    logic [AW-1:0] fwd_addr;
    logic [7:0]    fwd_data;
    logic          irq_save, irq_restore;
    logic [CW-1:0] retire_count;

    always #5 clk = ~clk;

    alu_writeback #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .accum_write(accum_write), .reg_write(reg_write),
        .reg_addr(reg_addr), .z_write(z_write), .zout(zout), .c_write(c_write),
        .cout(cout), .accum(accum), .zflag(zflag), .cflag(cflag),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .rf_wr_ack(rf_wr_ack), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data), .irq_save(irq_save), .irq_restore(irq_restore),
        .retire_count(retire_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural state {accum, z, c}, its shadow, one buffered write.
    logic [9:0]    m_arch, m_shadow;
    logic          m_pend;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_data;
    int            m_cnt;
    logic [11:0]   exp_q[$];
    logic [11:0]   obs_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        if (m_pend) void'(exp_q.pop_back());
        m_arch = 10'd0; m_shadow = 10'd0; m_pend = 1'b0;
        m_addr = '0; m_data = 8'h00; m_cnt = 0;
    endtask

    task automatic check_all();
        check("accum", accum, m_arch[9:2]);
        check("zflag", zflag, m_arch[1]);
        check("cflag", cflag, m_arch[0]);
        check("rf_wr_en", rf_wr_en, m_pend);
        check("rf_wr_addr", rf_wr_addr, m_addr);
        check("rf_wr_data", rf_wr_data, m_data);
        check("fwd", {fwd_valid, fwd_addr, fwd_data}, {m_pend, m_addr, m_data});
        check("retire_count", retire_count, m_cnt % (1 << CW));
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; result = 8'h00; accum_write = 1'b0; reg_write = 1'b0;
        reg_addr = '0; z_write = 1'b0; zout = 1'b0; c_write = 1'b0; cout = 1'b0;
        rf_wr_ack = 1'b0; irq_save = 1'b0; irq_restore = 1'b0;
    endtask

    task automatic op(input logic v, input logic aw, input logic rw, input logic [AW-1:0] a,
                      input logic [7:0] r, input logic zw, input logic zo,
                      input logic cw, input logic co, input logic ack);
        idle_inputs();
        in_valid = v; accum_write = aw; reg_write = rw; reg_addr = a; result = r;
        z_write = zw; zout = zo; c_write = cw; cout = co; rf_wr_ack = ack;
    endtask

    // Apply the current inputs for one cycle, advance the model, check after the edge.
    task automatic step();
        logic       acc;
        logic [9:0] next_arch;
        #1;
        check("in_ready", in_ready, !m_pend || rf_wr_ack);
        acc = in_valid && (!m_pend || rf_wr_ack);
        if (rf_wr_en && rf_wr_ack) obs_q.push_back({rf_wr_addr, rf_wr_data});
        next_arch = m_arch;
        if (acc) begin
            m_cnt = m_cnt + 1;
            if (accum_write) next_arch[9:2] = result;
            if (z_write) next_arch[1] = zout;
            if (c_write) next_arch[0] = cout;
        end
        if (irq_restore) next_arch = m_shadow;
        if (irq_save) m_shadow = m_arch;
        m_arch = next_arch;
        if (acc && reg_write) begin
            m_pend = 1'b1; m_addr = reg_addr; m_data = result;
            exp_q.push_back({reg_addr, result});
        end else if (rf_wr_ack) begin
            m_pend = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int base;
        idle_inputs();
        reset_n = 1'b0;
        m_pend = 1'b0;
        model_reset();
        #12;
        check("reset_in_ready", in_ready, 1'b1);
        check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Accumulator and flags.
        op(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); step();
        check("acc0_value", {accum, zflag, cflag, retire_count}, {8'h00, 1'b1, 1'b1, 16'd1});
        op(1'b1, 1'b1, 1'b0, 4'd0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step();
        check("acc5a_value", {accum, cflag}, {8'h5A, 1'b1});

        // Backpressure: write held for three cycles, then retire plus same-cycle accept.
        op(1'b1, 1'b0, 1'b1, 4'd3, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step();
        for (int i = 0; i < 3; i++) begin
            op(1'b1, 1'b1, 1'b1, 4'd9, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            check("bp_ready_low", in_ready, 1'b0);
            check("bp_write", {rf_wr_en, rf_wr_addr, rf_wr_data}, {1'b1, 4'd3, 8'hA5});
            step();
        end
        op(1'b1, 1'b0, 1'b1, 4'd7, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); step();
        check("bp_next", {rf_wr_en, fwd_addr, fwd_data}, {1'b1, 4'd7, 8'h3C});

        // Streaming with ack tied high.
        base = m_cnt;
        for (int i = 0; i < 10; i++) begin
            op(1'b1, 1'b0, 1'b1, 4'($urandom_range(0, 15)), 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            step();
        end
        check("stream_count", retire_count, 16'(base + 10));
        op(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); step();

        // Shadow save and restore.
        op(1'b1, 1'b1, 1'b0, 4'd0, 8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); step();
        op(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); irq_save = 1'b1; step();
        op(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step();
        check("sh_modified", {accum, zflag}, {8'h00, 1'b1});
        op(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); irq_restore = 1'b1; step();
        check("sh_restored", {accum, zflag, cflag}, {8'h11, 1'b0, 1'b1});

        // Collisions: restore beats accept; save+restore swaps.
        op(1'b1, 1'b1, 1'b0, 4'd0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step();
        base = m_cnt;
        op(1'b1, 1'b1, 1'b0, 4'd0, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); irq_restore = 1'b1; step();
        check("col_restore", {accum, retire_count}, {8'h11, 16'(base + 1)});
        op(1'b1, 1'b1, 1'b0, 4'd0, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); step();
        op(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        irq_save = 1'b1; irq_restore = 1'b1; step();
        check("swap_arch", {accum, zflag, cflag}, {8'h11, 1'b0, 1'b1});
        op(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); irq_restore = 1'b1; step();
        check("swap_shadow", {accum, zflag, cflag}, {8'h33, 1'b1, 1'b0});

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            op($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2) != 0);
            irq_save    = $urandom_range(0, 9) == 0;
            irq_restore = $urandom_range(0, 9) == 0;
            step();
        end

        // Reset in the middle of a pending write.
        op(1'b1, 1'b1, 1'b1, 4'd5, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); step();
        check("pre_reset_pend", rf_wr_en, 1'b1);
        idle_inputs();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("reset_in_ready_async", in_ready, 1'b1);
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
        op(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); step();
        check("post_reset_en", rf_wr_en, 1'b0);

        // Drain any buffered write, then compare the write stream in order.
        op(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); step();
        check("write_stream_len", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check("write_stream", obs_q[i], exp_q[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback stage that sits directly downstream of the ALU and consumes its result and write/flag strobes. Holds the architectural accumulator and Z/C flags that feed back into the ALU's `accum` and `cin` inputs. Buffers one pending register-file write behind a ready/ack handshake, forwards that pending write for hazard bypass, and keeps a one-deep interrupt shadow of accumulator and flags.

## Interface
- `ADDR_WIDTH`, default 4: register-file address width.
- `CNT_WIDTH`, default 16: width of the retired-operation counter.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  ALU output is valid this cycle.
- `in_ready`  out  1  stage can accept this cycle.
- `result`  in  8  ALU result.
- `accum_write`  in  1  write result to accumulator.
- `reg_write`  in  1  write result to register file.
- `reg_addr`  in  ADDR_WIDTH  destination register.
- `z_write`, `zout`  in  1 each  Z flag update enable and value.
- `c_write`, `cout`  in  1 each  C flag update enable and value.
- `accum`  out  8  architectural accumulator, to ALU `accum`.
- `zflag`  out  1  Z flag.
- `cflag`  out  1  C flag, to ALU `cin`.
- `rf_wr_en`  out  1  pending register write presented.
- `rf_wr_addr`  out  ADDR_WIDTH  pending write address.
- `rf_wr_data`  out  8  pending write data.
- `rf_wr_ack`  in  1  register file accepts pending write this cycle.
- `fwd_valid`, `fwd_addr`, `fwd_data`  out  1 / ADDR_WIDTH / 8  bypass of pending write; equal to `rf_wr_en`, `rf_wr_addr`, `rf_wr_data`.
- `irq_save`  in  1  pulse: copy {accum, Z, C} to shadow.
- `irq_restore`  in  1  pulse: load {accum, Z, C} from shadow.
- `retire_count`  out  CNT_WIDTH  accepted operations since reset.

## Operation
- **Accept:** `accept = in_valid && in_ready`.
- **Ready:** `in_ready = !pend || rf_wr_ack`. This is combinational, so a pending write can retire and a new operation can be accepted in the same cycle.
- **Pending write state:** `pend` is a 1-bit register.
  - On accept with `reg_write=1`: `pend <= 1`, `rf_wr_addr <= reg_addr`, `rf_wr_data <= result`.
  - Else, if `rf_wr_ack`: `pend <= 0`.
  - `rf_wr_en = pend`.
  - The addr/data registers hold their values while `pend=0`.
- **Accumulator:** on accept with `accum_write=1`, `accum <= result`.
  - Both `accum_write` and `reg_write` may be 1; both actions occur.
  - Neither set (compare/test ops): only the flags update.
- **Flags:** on accept, if `z_write`, `zflag <= zout`; if `c_write`, `cflag <= cout`. Each flag is independent.
- **Counter:** `retire_count` increments by 1 on every accept and wraps modulo 2^CNT_WIDTH.
- **Shadow:** `irq_save` loads the shadow from the current pre-edge {accum, zflag, cflag}.
- **Restore priority:** `irq_restore` loads {accum, zflag, cflag} from the shadow and overrides any same-cycle accumulator/flag update from an accept. The register-file capture and the counter still proceed.
- **Save and restore in the same cycle:** the architectural state and the shadow swap.
- `rf_wr_ack` while `pend=0` is ignored.

## Timing
- **Reset (async, `reset_n=0`):**
  - `accum=0`, `zflag=0`, `cflag=0`, `pend=0` (so `rf_wr_en=0`, `fwd_valid=0`).
  - `rf_wr_addr=0`, `rf_wr_data=0`, shadow=0, `retire_count=0`.
  - `in_ready=1` during and after reset.
  - A pending write is discarded by reset.
- **Accumulator/flag latency:** 1 cycle. State is visible the cycle after the accept edge, which gives back-to-back ALU ops the correct dependency.
- **Register write latency:** `rf_wr_en` rises the cycle after accept and stays high until the edge on which `rf_wr_ack=1`.
- **Throughput:**
  - With `rf_wr_ack` tied high: one operation per cycle.
  - With ack withheld: `in_ready=0` while pending, and at most one write is buffered.
- `in_ready` depends combinationally on `rf_wr_ack` only. There is no combinational path from `in_valid` to `in_ready`.

## Test plan
- **Reset:** assert `reset_n=0` mid-pending write -> all outputs 0 and `in_ready=1` immediately; after release, `rf_wr_en` stays 0.
- **Accumulator and flags:** accept `result=8'h00`, `accum_write=1`, `z_write=1`, `zout=1`, `c_write=1`, `cout=1` -> next cycle `accum=00`, Z=1, C=1, `retire_count=1`. Then accept `result=8'h5A` with `c_write=0` -> `accum=5A`, C stays 1.
- **Backpressure:** accept `reg_write=1`, `reg_addr=3`, `result=8'hA5` with `rf_wr_ack=0` -> `rf_wr_en=1`, addr 3, data A5, `fwd_*` identical, `in_ready=0` for 3 cycles. Raise ack together with a new `reg_write` to addr 7, data 3C -> same-cycle accept, next cycle shows 7/3C.
- **Streaming:** ack tied high, 10 consecutive accepts -> `in_ready` never drops, `retire_count=10`, 10 writes seen in order.
- **Shadow:** `accum=11`, Z=0, C=1, then `irq_save`; accept `result=00` with `accum_write`/`z_write`/`zout=1` -> `accum=00`, Z=1. Then `irq_restore` -> `accum=11`, Z=0, C=1.
- **Collisions:** `irq_restore` on the same cycle as an accept with `accum_write=1`, `result=77` -> shadow value wins, counter increments. `irq_save` and `irq_restore` together -> state and shadow swap.
